// File: rtl/teclado_cajero.sv
// Keypad front-end for the ATM controller: forwards PIN digits or builds a binary amount.
// All outputs registered, one cycle after the key; no backpressure, every strobed key is consumed.
module teclado_cajero #(
  parameter int NUM_DIG_PIN   = 4,
  parameter int MAX_DIG_MONTO = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HABILITAR,
  input  logic        MODO,
  input  logic        TECLA_STB,
  input  logic [3:0]  TECLA,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic [15:0] MONTO,
  output logic        MONTO_STB,
  output logic        DESBORDE,
  output logic [2:0]  CONTEO
);

  typedef enum logic [1:0] {INACTIVO, PIN, CANT} estado_t;

  localparam logic [2:0] L_MAX_PIN   = 3'(NUM_DIG_PIN);
  localparam logic [2:0] L_MAX_MONTO = 3'(MAX_DIG_MONTO);
  localparam logic [3:0] K_CLEAR     = 4'hA;
  localparam logic [3:0] K_ENTER     = 4'hB;

  estado_t     r_estado;
  logic [15:0] r_acc;
  logic [2:0]  r_conteo;
  logic [3:0]  r_digito;
  logic        r_digito_stb;
  logic [15:0] r_monto;
  logic        r_monto_stb;
  logic        r_desborde;

  estado_t     w_estado_sig;
  logic [15:0] w_acc_n;
  logic [2:0]  w_conteo_n;
  logic [3:0]  w_digito_n;
  logic        w_digito_stb_n;
  logic [15:0] w_monto_n;
  logic        w_monto_stb_n;
  logic        w_desborde_n;
  logic [19:0] w_nxt;
  logic        w_es_digito;

  assign w_nxt       = {4'd0, r_acc} * 20'd10 + {16'd0, TECLA};
  assign w_es_digito = (TECLA <= 4'd9);

  always_comb begin
    w_estado_sig   = HABILITAR ? (MODO ? CANT : PIN) : INACTIVO;
    w_acc_n        = r_acc;
    w_conteo_n     = r_conteo;
    w_digito_n     = r_digito;
    w_digito_stb_n = 1'b0;
    w_monto_n      = r_monto;
    w_monto_stb_n  = 1'b0;
    w_desborde_n   = 1'b0;

    // A mode change wins over any key arriving in the same cycle.
    if (w_estado_sig != r_estado) begin
      w_acc_n    = '0;
      w_conteo_n = '0;
    end else if (TECLA_STB) begin
      case (r_estado)
        PIN: begin
          if (w_es_digito) begin
            if (r_conteo < L_MAX_PIN) begin
              w_digito_n     = TECLA;
              w_digito_stb_n = 1'b1;
              w_conteo_n     = r_conteo + 3'd1;
            end else begin
              w_desborde_n = 1'b1;
            end
          end else if (TECLA == K_CLEAR) begin
            w_conteo_n = '0;
          end
        end
        CANT: begin
          if (w_es_digito) begin
            if ((r_conteo == L_MAX_MONTO) || (w_nxt > 20'h0FFFF)) begin
              w_desborde_n = 1'b1;
            end else begin
              w_acc_n    = w_nxt[15:0];
              w_conteo_n = r_conteo + 3'd1;
            end
          end else if (TECLA == K_CLEAR) begin
            w_acc_n    = '0;
            w_conteo_n = '0;
          end else if ((TECLA == K_ENTER) && (r_conteo != 3'd0)) begin
            w_monto_n     = r_acc;
            w_monto_stb_n = 1'b1;
            w_acc_n       = '0;
            w_conteo_n    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado     <= INACTIVO;
      r_acc        <= '0;
      r_conteo     <= '0;
      r_digito     <= '0;
      r_digito_stb <= 1'b0;
      r_monto      <= '0;
      r_monto_stb  <= 1'b0;
      r_desborde   <= 1'b0;
    end else begin
      r_estado     <= w_estado_sig;
      r_acc        <= w_acc_n;
      r_conteo     <= w_conteo_n;
      r_digito     <= w_digito_n;
      r_digito_stb <= w_digito_stb_n;
      r_monto      <= w_monto_n;
      r_monto_stb  <= w_monto_stb_n;
      r_desborde   <= w_desborde_n;
    end
  end

  assign DIGITO     = r_digito;
  assign DIGITO_STB = r_digito_stb;
  assign MONTO      = r_monto;
  assign MONTO_STB  = r_monto_stb;
  assign DESBORDE   = r_desborde;
  assign CONTEO     = r_conteo;

endmodule

// File: tb/tb_teclado_cajero.sv
// Bench for teclado_cajero: directed scenarios pinned with literals, then random keys vs. a rule model.
module tb_teclado_cajero;

  logic        clk = 1'b0;
  logic        reset, HABILITAR, MODO, TECLA_STB;
  logic [3:0]  TECLA;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic [15:0] MONTO;
  logic        MONTO_STB;
  logic        DESBORDE;
  logic [2:0]  CONTEO;

  int total = 0;
  int bad   = 0;

  // Model state: mode 0 = idle, 1 = PIN, 2 = amount.
  int m_mode, m_acc, m_cnt, m_dig, m_monto;
  bit m_dstb, m_mstb, m_desb;

  bit hab_cur, modo_cur;

  teclado_cajero #(.NUM_DIG_PIN(4), .MAX_DIG_MONTO(5)) dut (
    .clk(clk), .reset(reset), .HABILITAR(HABILITAR), .MODO(MODO),
    .TECLA_STB(TECLA_STB), .TECLA(TECLA), .DIGITO(DIGITO),
    .DIGITO_STB(DIGITO_STB), .MONTO(MONTO), .MONTO_STB(MONTO_STB),
    .DESBORDE(DESBORDE), .CONTEO(CONTEO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit h, input bit mo, input bit s, input int k);
    int nm, nxt;
    m_dstb = 0; m_mstb = 0; m_desb = 0;
    if (r) begin
      m_mode = 0; m_acc = 0; m_cnt = 0; m_dig = 0; m_monto = 0;
      return;
    end
    nm = !h ? 0 : (mo ? 2 : 1);
    if (nm != m_mode) begin
      m_mode = nm; m_acc = 0; m_cnt = 0;
    end else if (s) begin
      if (m_mode == 1) begin
        if (k < 10) begin
          if (m_cnt < 4) begin m_dig = k; m_dstb = 1; m_cnt++; end
          else m_desb = 1;
        end else if (k == 10) m_cnt = 0;
      end else if (m_mode == 2) begin
        if (k < 10) begin
          nxt = m_acc * 10 + k;
          if (m_cnt == 5 || nxt > 65535) m_desb = 1;
          else begin m_acc = nxt; m_cnt++; end
        end else if (k == 10) begin
          m_acc = 0; m_cnt = 0;
        end else if (k == 11 && m_cnt > 0) begin
          m_monto = m_acc; m_mstb = 1; m_acc = 0; m_cnt = 0;
        end
      end
    end
  endtask

  // One clock: drive, advance model, then compare every output after the edge.
  task automatic cyc(input bit r, input bit h, input bit mo, input bit s, input int k);
    reset = r; HABILITAR = h; MODO = mo; TECLA_STB = s; TECLA = 4'(k);
    model_step(r, h, mo, s, k);
    @(posedge clk);
    #1;
    chk("DIGITO", int'(DIGITO), m_dig);
    chk("DIGITO_STB", int'(DIGITO_STB), int'(m_dstb));
    chk("MONTO", int'(MONTO), m_monto);
    chk("MONTO_STB", int'(MONTO_STB), int'(m_mstb));
    chk("DESBORDE", int'(DESBORDE), int'(m_desb));
    chk("CONTEO", int'(CONTEO), m_cnt);
  endtask

  task automatic key(input int k);
    cyc(0, hab_cur, modo_cur, 1, k);
  endtask

  task automatic idle();
    cyc(0, hab_cur, modo_cur, 0, 0);
  endtask

  initial begin
    m_mode = 0; m_acc = 0; m_cnt = 0; m_dig = 0; m_monto = 0;
    m_dstb = 0; m_mstb = 0; m_desb = 0;
    hab_cur = 0; modo_cur = 0;

    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 5);
    chk("rst_digito", int'(DIGITO), 0);
    chk("rst_monto", int'(MONTO), 0);
    chk("rst_conteo", int'(CONTEO), 0);
    chk("rst_strobes", int'({DIGITO_STB, MONTO_STB, DESBORDE}), 0);

    // PIN: four digits forwarded, fifth rejected
    hab_cur = 1; modo_cur = 0;
    idle();
    for (int i = 1; i <= 4; i++) begin
      key(i);
      chk("pin_stb", int'(DIGITO_STB), 1);
      chk("pin_dig", int'(DIGITO), i);
    end
    chk("pin_cnt4", int'(CONTEO), 4);
    key(7);
    chk("pin5_stb", int'(DIGITO_STB), 0);
    chk("pin5_desb", int'(DESBORDE), 1);
    chk("pin5_dig", int'(DIGITO), 4);

    // Amount 150
    modo_cur = 1;
    idle();
    key(1); key(5); key(0); key(11);
    chk("m150", int'(MONTO), 150);
    chk("m150_stb", int'(MONTO_STB), 1);
    chk("m150_cnt", int'(CONTEO), 0);
    idle();
    chk("m150_stb_off", int'(MONTO_STB), 0);

    // 65535 fits, 65536 overflows
    key(6); key(5); key(5); key(3); key(5); key(11);
    chk("m65535", int'(MONTO), 65535);
    key(6); key(5); key(5); key(3); key(6);
    chk("ovf_desb", int'(DESBORDE), 1);
    chk("ovf_cnt", int'(CONTEO), 4);
    key(11);
    chk("m6553", int'(MONTO), 6553);

    // Digit limit: five zeros then a sixth digit
    key(0); key(0); key(0); key(0); key(0); key(1);
    chk("lim_desb", int'(DESBORDE), 1);
    chk("lim_cnt", int'(CONTEO), 5);
    key(10);

    // CLEAR then ENTER: nothing committed
    key(9); key(10); key(11);
    chk("clr_no_stb", int'(MONTO_STB), 0);
    key(2); key(11);
    chk("m2", int'(MONTO), 2);

    // Mode change drops the key in the same cycle
    key(4); key(2);
    modo_cur = 0;
    key(8);
    chk("chg_dstb", int'(DIGITO_STB), 0);
    chk("chg_cnt", int'(CONTEO), 0);
    modo_cur = 1;
    idle();
    key(11);
    chk("chg_no_m", int'(MONTO_STB), 0);

    // Reset mid-entry
    key(3); key(3);
    cyc(1, 1, 1, 1, 11);
    key(11);
    chk("rst_mid_m", int'(MONTO_STB), 0);
    chk("rst_mid_monto", int'(MONTO), 0);
    chk("rst_mid_dig", int'(DIGITO), 0);

    // Disabled: keys ignored
    hab_cur = 0;
    idle();
    key(5); key(11);
    chk("dis_strobes", int'({DIGITO_STB, MONTO_STB, DESBORDE}), 0);

    // Random phase
    hab_cur = 1;
    for (int n = 0; n < 4000; n++) begin
      bit r, s;
      int k;
      r = ($urandom % 250) == 0;
      if (($urandom % 40) == 0) modo_cur = ~modo_cur;
      if (($urandom % 120) == 0) hab_cur = ~hab_cur;
      s = ($urandom % 4) != 0;
      k = (($urandom % 5) == 0) ? 11 : int'($urandom % 16);
      cyc(r, hab_cur, modo_cur, s, k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/teclado_cajero.md
Name: teclado_cajero

Overview:
Keypad front-end stage that sits directly upstream of the ATM transaction controller and feeds its DIGITO/DIGITO_STB and MONTO/MONTO_STB inputs. It accepts raw key codes with a strobe and operates in one of two modes. In PIN mode it forwards up to NUM_DIG_PIN digits one at a time. In amount mode it accumulates decimal digits into a 16-bit binary amount and releases it on ENTER.

Parameters:
NUM_DIG_PIN, 4, digits forwarded per PIN entry before further digits are ignored
MAX_DIG_MONTO, 5, maximum decimal digits accepted for one amount

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
HABILITAR  input  1  card present; when 0 all keys are ignored and entry state is cleared
MODO  input  1  0 = PIN entry, 1 = amount entry
TECLA_STB  input  1  one-cycle key-pressed strobe
TECLA  input  4  key code: 0-9 digit, 4'hA CLEAR, 4'hB ENTER, 4'hC-4'hF ignored
DIGITO  output  4  last forwarded PIN digit
DIGITO_STB  output  1  one-cycle pulse, DIGITO valid
MONTO  output  16  last committed amount, binary
MONTO_STB  output  1  one-cycle pulse, MONTO valid
DESBORDE  output  1  one-cycle pulse, rejected digit (overflow or digit limit)
CONTEO  output  3  digits held in the current entry

Behaviour:
- Single clock, synchronous active-high reset; one clock domain.
- Reset values: DIGITO=0, DIGITO_STB=0, MONTO=0, MONTO_STB=0, DESBORDE=0, CONTEO=0. Internal state: acc=0, state=INACTIVO.
- States:
  - INACTIVO (HABILITAR=0)
  - PIN (HABILITAR=1, MODO=0)
  - CANT (HABILITAR=1, MODO=1)
- State is re-evaluated every cycle from HABILITAR/MODO, which take priority over any key.
- Any state change (including entering or leaving INACTIVO): acc=0, CONTEO=0. A key strobed in that same cycle is dropped. MONTO and DIGITO hold their values.
- All strobes are registered: key in cycle N -> output pulse in cycle N+1, high exactly one cycle.
- At most one output strobe per cycle.
- PIN state:
  - Digit with CONTEO<NUM_DIG_PIN: DIGITO<=TECLA, DIGITO_STB pulse, CONTEO+1.
  - Digit with CONTEO==NUM_DIG_PIN: ignored, DESBORDE pulse.
  - CLEAR: CONTEO=0, no strobe.
  - ENTER: ignored.
- CANT state:
  - Digit: compute nxt=acc*10+TECLA at 20-bit width.
    - If CONTEO==MAX_DIG_MONTO or nxt>16'hFFFF: acc unchanged, DESBORDE pulse.
    - Otherwise: acc<=nxt[15:0], CONTEO+1.
  - Leading zeros are accepted and counted.
  - ENTER with CONTEO>0: MONTO<=acc, MONTO_STB pulse, then acc=0, CONTEO=0.
  - ENTER with CONTEO==0: ignored, no strobe.
  - CLEAR: acc=0, CONTEO=0.
- INACTIVO: all keys ignored, no strobes.
- Codes 4'hC-4'hF are ignored in every state with no side effects.
- TECLA_STB held high for consecutive cycles: each cycle counts as a separate key.
- Reset mid-entry: everything returns to reset values the next cycle. A key strobed in the reset cycle is dropped.

Test Plan:
- Reset, then HABILITAR=1, MODO=0, keys 1,2,3,4 on consecutive cycles -> DIGITO_STB pulses on 4 consecutive cycles with DIGITO 1,2,3,4; CONTEO ends at 4. A fifth key 7 -> no DIGITO_STB, DESBORDE pulse, DIGITO stays 4.
- MODO=1, keys 1,5,0, ENTER -> one cycle after ENTER: MONTO=150, MONTO_STB high one cycle, CONTEO=0.
- MODO=1, keys 6,5,5,3,5, ENTER -> MONTO=65535. Keys 6,5,5,3,6 -> fifth key gives DESBORDE pulse; ENTER then gives MONTO=6553.
- MODO=1, keys 9,CLEAR,ENTER -> no MONTO_STB. Then key 2, ENTER -> MONTO=2.
- Keys 4,2 in CANT, then MODO toggles to 0 in the same cycle as key 8 -> key dropped, no strobes, CONTEO=0. Return to MODO=1, ENTER -> no MONTO_STB.
- Keys 3,3 in CANT, reset pulsed for one cycle, then ENTER -> no MONTO_STB, all outputs at reset values. Also: HABILITAR=0 with any key -> no strobes.
